// File: rtl/ofu_pkg.sv
// Shared types for the operand fetch unit: pipeline slot records and index helpers.
// The records use the package widths; the top-level DATA_WIDTH/ADDR_WIDTH must match them.
package ofu_pkg;

  localparam int unsigned TagWidth     = 8;
  localparam int unsigned OfuDataWidth = 32;
  localparam int unsigned OfuAddrWidth = 8;

  // Instruction in the register-file read slot, plus the writeback seen at issue.
  typedef struct packed {
    logic [OfuAddrWidth-1:0] src_a;
    logic [OfuAddrWidth-1:0] src_b;
    logic [OfuAddrWidth-1:0] dst;
    logic                    dst_valid;
    logic [TagWidth-1:0]     tag;
    logic                    wb_valid;
    logic [OfuAddrWidth-1:0] wb_addr;
    logic [OfuDataWidth-1:0] wb_data;
  } r_slot_t;

  typedef struct packed {
    logic [OfuDataWidth-1:0] operand_a;
    logic [OfuDataWidth-1:0] operand_b;
    logic [OfuAddrWidth-1:0] dst;
    logic                    dst_valid;
    logic [TagWidth-1:0]     tag;
  } o_slot_t;

  function automatic logic idx_in_range(input logic [OfuAddrWidth-1:0] idx,
                                        input int unsigned mem_size);
    return 32'(idx) <= mem_size;
  endfunction

endpackage

// File: rtl/ofu_scoreboard.sv
// Pending-destination scoreboard. Lookups see this cycle's clear; a same-cycle set wins over clear.
module ofu_scoreboard
  import ofu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = OfuAddrWidth,
  parameter int unsigned MEM_SIZE   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_idx,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_idx,
  input  logic [ADDR_WIDTH-1:0] i_src_a,
  input  logic [ADDR_WIDTH-1:0] i_src_b,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_busy_dst
);

  logic [MEM_SIZE:0] r_bits;
  logic [MEM_SIZE:0] w_set_mask;
  logic [MEM_SIZE:0] w_clr_mask;
  logic [MEM_SIZE:0] w_after_clr;
  logic [MEM_SIZE:0] w_hit_a;
  logic [MEM_SIZE:0] w_hit_b;
  logic [MEM_SIZE:0] w_hit_dst;

  // Indices above MEM_SIZE match no bit, so they are never pending.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    w_hit_a    = '0;
    w_hit_b    = '0;
    w_hit_dst  = '0;
    for (int unsigned i = 0; i <= MEM_SIZE; i++) begin
      w_set_mask[i] = i_set_en && (i_set_idx == ADDR_WIDTH'(i));
      w_clr_mask[i] = i_clr_en && (i_clr_idx == ADDR_WIDTH'(i));
      w_hit_a[i]    = (i_src_a == ADDR_WIDTH'(i));
      w_hit_b[i]    = (i_src_b == ADDR_WIDTH'(i));
      w_hit_dst[i]  = (i_dst == ADDR_WIDTH'(i));
    end
  end

  assign w_after_clr = r_bits & ~w_clr_mask;
  assign o_busy_a    = |(w_after_clr & w_hit_a);
  assign o_busy_b    = |(w_after_clr & w_hit_b);
  assign o_busy_dst  = |(w_after_clr & w_hit_dst);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bits <= '0;
    end else begin
      r_bits <= w_after_clr | w_set_mask;
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: issue -> R (register file data) -> O (registered operands).
// Optional macro OFU_ZERO_REG_EN makes register 0 a hard-wired zero.
module operand_fetch_unit
  import ofu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OfuDataWidth,
  parameter int unsigned ADDR_WIDTH = OfuAddrWidth,
  parameter int unsigned MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  iReset_n,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [ADDR_WIDTH-1:0] iSrcA,
  input  logic [ADDR_WIDTH-1:0] iSrcB,
  input  logic [ADDR_WIDTH-1:0] iDst,
  input  logic                  iDstValid,
  input  logic [TagWidth-1:0]   iTag,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamData0,
  input  logic [DATA_WIDTH-1:0] iRamData1,
  input  logic                  iWbValid,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oOperandA,
  output logic [DATA_WIDTH-1:0] oOperandB,
  output logic [ADDR_WIDTH-1:0] oDst,
  output logic                  oDstValid,
  output logic [TagWidth-1:0]   oTag
);

  r_slot_t               r_rslot;
  logic                  r_rvalid;
  logic                  r_fresh;
  logic [DATA_WIDTH-1:0] r_hold_a;
  logic [DATA_WIDTH-1:0] r_hold_b;
  o_slot_t               r_oslot;
  logic                  r_ovalid;

  logic                  w_busy_a;
  logic                  w_busy_b;
  logic                  w_busy_dst;
  logic                  w_hazard;
  logic                  w_issue;
  logic                  w_r_adv;
  logic                  w_set_en;
  logic                  w_zero_dst;
  logic                  w_zero_wb;
  logic                  w_zero_ra;
  logic                  w_zero_rb;
  logic [DATA_WIDTH-1:0] w_fresh_a;
  logic [DATA_WIDTH-1:0] w_fresh_b;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  r_slot_t               w_rslot_next;
  o_slot_t               w_oslot_next;

`ifdef OFU_ZERO_REG_EN
  assign w_zero_dst = (iDst == '0);
  assign w_zero_wb  = (iWbAddr == '0);
  assign w_zero_ra  = (r_rslot.src_a == '0);
  assign w_zero_rb  = (r_rslot.src_b == '0);
`else
  assign w_zero_dst = 1'b0;
  assign w_zero_wb  = 1'b0;
  assign w_zero_ra  = 1'b0;
  assign w_zero_rb  = 1'b0;
`endif

  assign oReadAddress0 = iSrcA;
  assign oReadAddress1 = iSrcB;
  assign oWriteEnable  = iWbValid && !w_zero_wb;
  assign oWriteAddress = iWbAddr;
  assign oWriteData    = iWbData;

  assign w_set_en = w_issue && iDstValid && !w_zero_dst;

  ofu_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_scoreboard (
    .i_clk      (Clock),
    .i_rst_n    (iReset_n),
    .i_set_en   (w_set_en),
    .i_set_idx  (iDst),
    .i_clr_en   (iWbValid),
    .i_clr_idx  (iWbAddr),
    .i_src_a    (iSrcA),
    .i_src_b    (iSrcB),
    .i_dst      (iDst),
    .o_busy_a   (w_busy_a),
    .o_busy_b   (w_busy_b),
    .o_busy_dst (w_busy_dst)
  );

  assign w_hazard = w_busy_a || w_busy_b || (iDstValid && w_busy_dst);
  assign w_r_adv  = r_rvalid && (!r_ovalid || iReady);
  assign oReady   = !w_hazard && (!r_rvalid || !r_ovalid || iReady);
  assign w_issue  = iValid && oReady;

  always_comb begin
    w_rslot_next           = '0;
    w_rslot_next.src_a     = iSrcA;
    w_rslot_next.src_b     = iSrcB;
    w_rslot_next.dst       = iDst;
    w_rslot_next.dst_valid = iDstValid;
    w_rslot_next.tag       = iTag;
    w_rslot_next.wb_valid  = iWbValid && !w_zero_wb;
    w_rslot_next.wb_addr   = iWbAddr;
    w_rslot_next.wb_data   = iWbData;
  end

  // The register file read in the issue cycle missed that cycle's write; patch it here.
  always_comb begin
    w_fresh_a = iRamData0;
    w_fresh_b = iRamData1;
    if (r_rslot.wb_valid && (r_rslot.wb_addr == r_rslot.src_a) &&
        idx_in_range(r_rslot.src_a, MEM_SIZE)) begin
      w_fresh_a = r_rslot.wb_data;
    end
    if (r_rslot.wb_valid && (r_rslot.wb_addr == r_rslot.src_b) &&
        idx_in_range(r_rslot.src_b, MEM_SIZE)) begin
      w_fresh_b = r_rslot.wb_data;
    end
    if (w_zero_ra) w_fresh_a = '0;
    if (w_zero_rb) w_fresh_b = '0;
  end

  // RAM data is only valid the cycle after issue; a stalled R slot uses its captured copy.
  assign w_op_a = r_fresh ? w_fresh_a : r_hold_a;
  assign w_op_b = r_fresh ? w_fresh_b : r_hold_b;

  always_comb begin
    w_oslot_next           = '0;
    w_oslot_next.operand_a = w_op_a;
    w_oslot_next.operand_b = w_op_b;
    w_oslot_next.dst       = r_rslot.dst;
    w_oslot_next.dst_valid = r_rslot.dst_valid;
    w_oslot_next.tag       = r_rslot.tag;
  end

  always_ff @(posedge Clock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rvalid <= 1'b0;
      r_fresh  <= 1'b0;
      r_rslot  <= '0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else if (w_issue) begin
      r_rvalid <= 1'b1;
      r_fresh  <= 1'b1;
      r_rslot  <= w_rslot_next;
    end else if (w_r_adv) begin
      r_rvalid <= 1'b0;
      r_fresh  <= 1'b0;
    end else if (r_rvalid && r_fresh) begin
      r_hold_a <= w_fresh_a;
      r_hold_b <= w_fresh_b;
      r_fresh  <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_ovalid <= 1'b0;
      r_oslot  <= '0;
    end else if (w_r_adv) begin
      r_ovalid <= 1'b1;
      r_oslot  <= w_oslot_next;
    end else if (r_ovalid && iReady) begin
      r_ovalid <= 1'b0;
    end
  end

  assign oValid    = r_ovalid;
  assign oOperandA = r_oslot.operand_a;
  assign oOperandB = r_oslot.operand_b;
  assign oDst      = r_oslot.dst;
  assign oDstValid = r_oslot.dst_valid;
  assign oTag      = r_oslot.tag;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench: issue vectors push hand-computed bundles; a negedge monitor checks handshakes.
module tb_operand_fetch_unit;

  logic        Clock;
  logic        iReset_n;
  logic        iValid;
  logic        oReady;
  logic [7:0]  iSrcA, iSrcB, iDst;
  logic        iDstValid;
  logic [7:0]  iTag;
  logic [7:0]  oReadAddress0, oReadAddress1;
  logic [31:0] iRamData0, iRamData1;
  logic        iWbValid;
  logic [7:0]  iWbAddr;
  logic [31:0] iWbData;
  logic        oWriteEnable;
  logic [7:0]  oWriteAddress;
  logic [31:0] oWriteData;
  logic        oValid;
  logic        iReady;
  logic [31:0] oOperandA, oOperandB;
  logic [7:0]  oDst;
  logic        oDstValid;
  logic [7:0]  oTag;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  dst;
    logic        dv;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] mem [0:255];

  operand_fetch_unit dut (
    .Clock         (Clock),
    .iReset_n      (iReset_n),
    .iValid        (iValid),
    .oReady        (oReady),
    .iSrcA         (iSrcA),
    .iSrcB         (iSrcB),
    .iDst          (iDst),
    .iDstValid     (iDstValid),
    .iTag          (iTag),
    .oReadAddress0 (oReadAddress0),
    .oReadAddress1 (oReadAddress1),
    .iRamData0     (iRamData0),
    .iRamData1     (iRamData1),
    .iWbValid      (iWbValid),
    .iWbAddr       (iWbAddr),
    .iWbData       (iWbData),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oValid        (oValid),
    .iReady        (iReady),
    .oOperandA     (oOperandA),
    .oOperandB     (oOperandB),
    .oDst          (oDst),
    .oDstValid     (oDstValid),
    .oTag          (oTag)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register file model: synchronous read returning the pre-write value.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end
  always @(posedge Clock) begin
    iRamData0 <= mem[oReadAddress0];
    iRamData1 <= mem[oReadAddress1];
    if (oWriteEnable) mem[oWriteAddress] <= oWriteData;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (iReset_n && oValid && iReady) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected got tag=%0h want none", oTag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_a", 64'(oOperandA), 64'(e.a));
        chk("out_b", 64'(oOperandB), 64'(e.b));
        chk("out_dst", 64'(oDst), 64'(e.dst));
        chk("out_dv", 64'(oDstValid), 64'(e.dv));
        chk("out_tag", 64'(oTag), 64'(e.tag));
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wb(input logic [7:0] a, input logic [31:0] d, input logic exp_we);
    iWbValid = 1'b1;
    iWbAddr  = a;
    iWbData  = d;
    @(negedge Clock);
    chk("wr_en", 64'(oWriteEnable), 64'(exp_we));
    if (exp_we) begin
      chk("wr_addr", 64'(oWriteAddress), 64'(a));
      chk("wr_data", 64'(oWriteData), 64'(d));
    end
    step();
    iWbValid = 1'b0;
  endtask

  task automatic drive(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] d,
                       input logic dv, input logic [7:0] tag);
    iValid    = 1'b1;
    iSrcA     = sa;
    iSrcB     = sb;
    iDst      = d;
    iDstValid = dv;
    iTag      = tag;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] d,
                              input logic dv, input logic [7:0] tag);
    exp_t e;
    e.a = a; e.b = b; e.dst = d; e.dv = dv; e.tag = tag;
    return e;
  endfunction

  // Waits (bounded) for acceptance of an instruction with no expected stall.
  task automatic issue(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] d,
                       input logic dv, input logic [7:0] tag,
                       input logic [31:0] ea, input logic [31:0] eb);
    drive(sa, sb, d, dv, tag);
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (oReady) break;
    end
    if (!oReady) begin
      total++;
      bad++;
      $display("FAIL issue_timeout got oReady=0 want 1 tag=%0h", tag);
    end else begin
      q.push_back(mk(ea, eb, d, dv, tag));
    end
    step();
    iValid = 1'b0;
  endtask

  // Issue that must be accepted in the current cycle.
  task automatic issue_now(input string name, input logic [7:0] sa, input logic [7:0] sb,
                           input logic [7:0] d, input logic dv, input logic [7:0] tag,
                           input logic [31:0] ea, input logic [31:0] eb);
    drive(sa, sb, d, dv, tag);
    @(negedge Clock);
    chk(name, 64'(oReady), 64'd1);
    if (oReady) q.push_back(mk(ea, eb, d, dv, tag));
    step();
    iValid = 1'b0;
  endtask

  task automatic expect_stall(input string name, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge Clock);
      chk(name, 64'(oReady), 64'd0);
      step();
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 30; n++) begin
      if (q.size() == 0) break;
      @(posedge Clock);
      #2;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    iReset_n = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iSrcA = '0; iSrcB = '0; iDst = '0; iDstValid = 1'b0; iTag = '0;
    iWbValid = 1'b0; iWbAddr = '0; iWbData = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_ovalid", 64'(oValid), 64'd0);
    chk("rst_ready", 64'(oReady), 64'd1);
    chk("rst_opa", 64'(oOperandA), 64'd0);
    @(negedge Clock);
    iReset_n = 1'b1;
    step();

    // Basic fetch and 2-cycle latency.
    wb(8'd3, 32'h11, 1'b1);
    wb(8'd4, 32'h22, 1'b1);
    issue(8'd3, 8'd4, 8'd5, 1'b1, 8'hA1, 32'h11, 32'h22);
    @(negedge Clock);
    chk("lat_r_slot", 64'(oValid), 64'd0);
    @(negedge Clock);
    chk("lat_o_slot", 64'(oValid), 64'd1);
    step();

    // RAW on r5: stall until the writeback, accepted that cycle via bypass.
    drive(8'd5, 8'd3, 8'd0, 1'b0, 8'hB3);
    expect_stall("raw_stall", 2);
    iWbValid = 1'b1; iWbAddr = 8'd5; iWbData = 32'hDEAD;
    @(negedge Clock);
    chk("raw_wb_accept", 64'(oReady), 64'd1);
    if (oReady) q.push_back(mk(32'hDEAD, 32'h11, 8'd0, 1'b0, 8'hB3));
    step();
    iValid = 1'b0; iWbValid = 1'b0;
    drain();

    // Back-pressure: O and R full, third instruction waits, then in-order drain.
    iReady = 1'b0;
    issue(8'd3, 8'd4, 8'd0, 1'b0, 8'h01, 32'h11, 32'h22);
    issue(8'd4, 8'd3, 8'd0, 1'b0, 8'h02, 32'h22, 32'h11);
    drive(8'd5, 8'd3, 8'd0, 1'b0, 8'h03);
    for (int n = 0; n < 4; n++) begin
      @(negedge Clock);
      chk("bp_ready", 64'(oReady), 64'd0);
      chk("bp_ovalid", 64'(oValid), 64'd1);
      chk("bp_hold_tag", 64'(oTag), 64'h01);
      chk("bp_hold_a", 64'(oOperandA), 64'h11);
      step();
    end
    iReady = 1'b1;
    @(negedge Clock);
    chk("bp_release_ready", 64'(oReady), 64'd1);
    if (oReady) q.push_back(mk(32'hDEAD, 32'h11, 8'd0, 1'b0, 8'h03));
    step();
    iValid = 1'b0;
    drain();

    // Same-cycle set and clear of r6: set wins, later read of r6 stalls.
    iWbValid = 1'b1; iWbAddr = 8'd6; iWbData = 32'h66;
    issue_now("setclr_issue", 8'd3, 8'd4, 8'd6, 1'b1, 8'h05, 32'h11, 32'h22);
    iWbValid = 1'b0;
    drive(8'd3, 8'd6, 8'd0, 1'b0, 8'h06);
    expect_stall("setclr_stall", 3);
    iWbValid = 1'b1; iWbAddr = 8'd6; iWbData = 32'h77;
    @(negedge Clock);
    chk("setclr_wb_accept", 64'(oReady), 64'd1);
    if (oReady) q.push_back(mk(32'h11, 32'h77, 8'd0, 1'b0, 8'h06));
    step();
    iValid = 1'b0; iWbValid = 1'b0;
    drain();

    // Register 0 behaviour.
`ifdef OFU_ZERO_REG_EN
    wb(8'd0, 32'h55, 1'b0);
    issue_now("zero_nostall0", 8'd0, 8'd0, 8'd0, 1'b1, 8'h07, 32'h0, 32'h0);
    issue_now("zero_nostall1", 8'd0, 8'd3, 8'd0, 1'b0, 8'h17, 32'h0, 32'h11);
`else
    wb(8'd0, 32'h55, 1'b1);
    issue_now("r0_issue", 8'd0, 8'd0, 8'd0, 1'b0, 8'h07, 32'h55, 32'h55);
`endif
    drain();

    // Mid-stream reset with O full.
    iReady = 1'b0;
    issue_now("prerst_issue", 8'd3, 8'd4, 8'd7, 1'b1, 8'h08, 32'h11, 32'h22);
    @(negedge Clock);
    @(negedge Clock);
    chk("prerst_ovalid", 64'(oValid), 64'd1);
    #2;
    iReset_n = 1'b0;
    #1;
    chk("midrst_ovalid", 64'(oValid), 64'd0);
    chk("midrst_tag", 64'(oTag), 64'd0);
    chk("midrst_opb", 64'(oOperandB), 64'd0);
    q.delete();
    @(posedge Clock);
    @(negedge Clock);
    iReset_n = 1'b1;
    iReady = 1'b1;
    #1;
    chk("postrst_ready", 64'(oReady), 64'd1);
    step();
    issue_now("postrst_sb_clear", 8'd7, 8'd7, 8'd7, 1'b1, 8'h09, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Operand-fetch stage placed directly upstream of the 32-bit dual-read-port register file. It accepts decoded instructions over a valid/ready handshake and drives the register file's two synchronous read addresses and its write port. It corrects for the register file's read-before-write behaviour with a bypass, tracks pending destinations in a scoreboard, and presents registered operand pairs to the execute stage.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and writeback width
- ADDR_WIDTH, 8, register address width
- MEM_SIZE, 8, highest valid register index; the scoreboard has MEM_SIZE+1 bits

Ports:
- Clock  in  1  single clock; all state updates on posedge
- iReset_n  in  1  asynchronous active-low reset
- iValid  in  1  upstream instruction valid
- oReady  out  1  upstream accept; transfer occurs when iValid && oReady
- iSrcA, iSrcB  in  ADDR_WIDTH  source register indices
- iDst  in  ADDR_WIDTH  destination register index
- iDstValid  in  1  instruction writes iDst
- iTag  in  8  opaque instruction tag, carried through to the output
- oReadAddress0, oReadAddress1  out  ADDR_WIDTH  to register file; combinational copies of iSrcA and iSrcB
- iRamData0, iRamData1  in  DATA_WIDTH  register file read data, valid one cycle after the address
- iWbValid, iWbAddr, iWbData  in  1/ADDR_WIDTH/DATA_WIDTH  writeback from execute
- oWriteEnable, oWriteAddress, oWriteData  out  1/ADDR_WIDTH/DATA_WIDTH  to register file; combinational pass-through of the writeback inputs
- oValid  out  1  operand bundle valid
- iReady  in  1  downstream accept
- oOperandA, oOperandB  out  DATA_WIDTH  registered operands
- oDst, oDstValid, oTag  out  registered copies of the instruction fields

## Operation
- Pipeline: issue (cycle N, addresses to the register file) -> R slot (cycle N+1, register file data valid) -> O slot (output register, visible in cycle N+2).
- Hazard stall: set when srcA, srcB or iDstValid&&iDst has its scoreboard bit set after this cycle's writeback clear.
  - A writeback in the same cycle clears the bit, so the matching instruction is not stalled.
  - Destination checking covers WAW hazards.
- oReady = !hazard && (!rValid || !oValid || iReady).
- R advances into O when !oValid || iReady. O clears on handshake when R is empty.
- Scoreboard:
  - Set on issue when iDstValid.
  - Clear on iWbValid for iWbAddr.
  - Set and clear of the same index in the same cycle: set wins.
- Bypass:
  - At issue, the unit records {wbValid, wbAddr, wbData} from the same cycle into the R slot.
  - In R, an operand whose source equals the recorded wbAddr takes wbData instead of iRamData, because the register file returned the old value.
  - No other bypass is needed, because the scoreboard blocks issue while any other write to a source is outstanding.
- Indices above MEM_SIZE are treated as never pending, and their read data passes through unchanged.

## Timing
- Reset: oValid=0, rValid=0, scoreboard all 0, O-slot data/tag/dst=0, bypass record cleared.
  - oReady goes to 1 as soon as reset deasserts.
  - In-flight instructions are discarded; writebacks in flight are not recovered.
- Latency is 2 cycles from accept to oValid.
- Throughput is 1 per cycle while iReady=1 and there are no hazards.
- Back-pressure: with O full and iReady=0, R holds and oReady=0. O holds stable until the handshake.
- Write pass-through has zero latency, and the register file commits at the next edge.

## Configuration
- OFU_ZERO_REG_EN defined:
  - Register 0 reads as 0 in both operands, overriding RAM data and bypass.
  - Register 0 is never set in the scoreboard and never causes a stall.
  - Writebacks to register 0 are suppressed: oWriteEnable=0.
- OFU_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- Shared package ofu_pkg holds:
  - the tag width constant (8)
  - the R-slot record typedef (srcA, srcB, dst, dstValid, tag, wbValid, wbAddr, wbData)
  - the O-slot record typedef
- One sub-module, ofu_scoreboard: a MEM_SIZE+1 bit vector with set/clear ports and two source lookups plus one destination lookup, each including the same-cycle clear.

## Test plan
1. Reset with iReset_n=0 mid-stream while oValid=1 -> oValid=0 and scoreboard=0 immediately; oReady=1 after deassert.
2. Preload r3=0x11, r4=0x22; issue srcA=3, srcB=4, dst=5 -> oValid two cycles later with A=0x11, B=0x22, oDst=5, tag preserved.
3. Issue dst=5, then srcA=5 -> oReady=0 until iWbValid, iWbAddr=5, iWbData=0xDEAD. Accept occurs in that same cycle, and oOperandA=0xDEAD via bypass.
4. Hold iReady=0 for 4 cycles with 3 issued instructions -> O and R hold and oReady=0. Releasing iReady drains them in order with no loss or duplication.
5. Issue dst=6 while a writeback to 6 occurs in the same cycle -> bit 6 remains set, and a subsequent srcB=6 stalls.
6. With OFU_ZERO_REG_EN, write 0x55 to r0, then read srcA=0 -> oWriteEnable=0, operand=0, no stall.
